vend_controller: RTL and testbench

- Sequencing controller for the coin-operated vending datapath: accumulates coin credit, arbitrates purchase/cancel requests, drives a dispense handshake, and returns change one coin-unit at a time.
- Sits between the coin acceptor / front-panel buttons and the dispenser and change-hopper actuators.
- Credit is counted in units of 5 (coin code 01 = 1 unit, 10 = 2 units).

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_timeout.sv | 36 +++
 rtl/vend_controller.sv | 162 ++++++++++++++++
 tb/tb_vend_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: definitions shared by the vending controller and its timeout counter.
//   state_t       : controller state encoding
//   COIN_*        : coin acceptor codes
//   UNIT_*        : credit value of each coin, in 5-units
//   *_DEF         : default parameter values for vend_controller
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COLLECT  = 2'b01,
    DISPENSE = 2'b10,
    CHANGE   = 2'b11
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam logic [1:0] UNIT_5  = 2'd1;
  localparam logic [1:0] UNIT_10 = 2'd2;

  localparam int PRICE_DEF      = 3;
  localparam int MAX_CREDIT_DEF = 7;
  localparam int CREDIT_W_DEF   = 3;
  localparam int TIMEOUT_DEF    = 200;
  localparam int TO_W_DEF       = 8;

endpackage

// File: rtl/vend_timeout.sv
// vend_timeout: idle-cycle counter for the COLLECT state.
//   clk  in  : system clock
//   rst  in  : asynchronous active-low reset
//   clr  in  : load the counter with 0 (wins over en)
//   en   in  : count up by one this cycle
//   tc   out : terminal count, high once TIMEOUT-1 idle cycles have elapsed
module vend_timeout #(
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  // Counter parks at LAST so tc stays asserted until the controller clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + TO_W'(1);
    end
  end

  // tc is seen during the 200th idle cycle, so the state change lands on that edge.
  assign tc = (count == LAST);

endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin credit, purchase/cancel arbitration, dispense and change sequencing.
//   clk       in  : system clock
//   rst       in  : asynchronous active-low reset
//   coin      in  : one-cycle coin code (00 none, 01 five, 10 ten, 11 invalid)
//   sel       in  : one-cycle purchase request
//   cancel    in  : one-cycle refund request
//   coin_acc  out : pulse, coin added to credit
//   coin_rej  out : pulse, coin must be returned
//   disp_req  out : level, dispense request held until disp_ack
//   disp_ack  in  : dispenser done
//   chg_req   out : level, eject one 5-unit of change
//   chg_ack   in  : one 5-unit ejected
//   credit    out : current credit in 5-units
//   short_err out : pulse, sel with insufficient credit
//   busy      out : high while dispensing or returning change
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE      = PRICE_DEF,
  parameter int MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int CREDIT_W   = CREDIT_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int TO_W       = TO_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel,
  input  logic                cancel,
  output logic                coin_acc,
  output logic                coin_rej,
  output logic                disp_req,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                short_err,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W + 1)'(MAX_CREDIT);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_ok;
  logic                accept;
  logic                reject;
  logic                short_nxt;
  logic                activity;
  logic                to_clr;
  logic                to_en;
  logic                to_tc;

  vend_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (to_clr),
    .en  (to_en),
    .tc  (to_tc)
  );

  // Coin valuation; the sum is one bit wider so an overflowing coin is caught by the compare.
  always_comb begin
    coin_val = '0;
    case (coin)
      COIN_5:   coin_val = {{(CREDIT_W - 1){1'b0}}, UNIT_5};
      COIN_10:  coin_val = {{(CREDIT_W - 1){1'b0}}, UNIT_10};
      COIN_BAD: coin_val = '0;
      default:  coin_val = '0;
    endcase
    credit_sum = {1'b0, credit} + coin_val;
    coin_ok    = ((coin == COIN_5) || (coin == COIN_10)) && (credit_sum <= MAX_C);
  end

  // Next-state and credit logic. In COLLECT, cancel beats sel beats coin; a coin that
  // arrives alongside a winning cancel or purchase is returned to the customer.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    accept     = 1'b0;
    short_nxt  = 1'b0;
    activity   = 1'b0;
    case (state)
      IDLE: begin
        if (sel) short_nxt = 1'b1;
        if (coin_ok) begin
          accept     = 1'b1;
          credit_nxt = credit_sum[CREDIT_W-1:0];
          state_nxt  = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          activity  = 1'b1;
          state_nxt = (credit == '0) ? IDLE : CHANGE;
        end else if (sel && (credit >= PRICE_C)) begin
          activity   = 1'b1;
          credit_nxt = credit - PRICE_C;
          state_nxt  = DISPENSE;
        end else begin
          if (sel) begin
            short_nxt = 1'b1;
            activity  = 1'b1;
          end
          if (coin_ok) begin
            accept     = 1'b1;
            activity   = 1'b1;
            credit_nxt = credit_sum[CREDIT_W-1:0];
          end
          if (!activity && to_tc) state_nxt = CHANGE;
        end
      end
      DISPENSE: begin
        if (disp_ack) state_nxt = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        // credit != 0 here is exactly the condition under which chg_req is high.
        if (credit == '0) begin
          state_nxt = IDLE;
        end else if (chg_ack) begin
          credit_nxt = credit - CREDIT_W'(1);
          if (credit == CREDIT_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    reject = (coin != COIN_NONE) && !accept;
    to_clr = (state != COLLECT) || activity;
    to_en  = (state == COLLECT);
  end

  // State and outputs are all registered; levels are derived from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      credit    <= '0;
      coin_acc  <= 1'b0;
      coin_rej  <= 1'b0;
      short_err <= 1'b0;
      disp_req  <= 1'b0;
      chg_req   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      credit    <= credit_nxt;
      coin_acc  <= accept;
      coin_rej  <= reject;
      short_err <= short_nxt;
      disp_req  <= (state_nxt == DISPENSE);
      chg_req   <= (state_nxt == CHANGE) && (credit_nxt != '0);
      busy      <= (state_nxt == DISPENSE) || (state_nxt == CHANGE);
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed scenarios for vend_controller. Each step drives one cycle
// of inputs and compares the full output vector
// {coin_acc, coin_rej, disp_req, chg_req, short_err, busy, credit[2:0]} after the edge.
module tb_vend_controller;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       sel;
  logic       cancel;
  logic       coin_acc;
  logic       coin_rej;
  logic       disp_req;
  logic       disp_ack;
  logic       chg_req;
  logic       chg_ack;
  logic [2:0] credit;
  logic       short_err;
  logic       busy;

  int checks;
  int failures;
  logic [8:0] exp;

  vend_controller dut (
    .clk       (clk),
    .rst       (rst),
    .coin      (coin),
    .sel       (sel),
    .cancel    (cancel),
    .coin_acc  (coin_acc),
    .coin_rej  (coin_rej),
    .disp_req  (disp_req),
    .disp_ack  (disp_ack),
    .chg_req   (chg_req),
    .chg_ack   (chg_ack),
    .credit    (credit),
    .short_err (short_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {coin_acc, coin_rej, disp_req, chg_req, short_err, busy, credit};
  endfunction

  // Present one cycle of inputs, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic [1:0] c, input logic s, input logic x,
                               input logic da, input logic ca);
    coin = c; sel = s; cancel = x; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    #1;
    coin = 2'b00; sel = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    exp = 9'b000000_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL reset_outputs got %b want %b", outs(), exp); end
    idle_cycles(1);
    checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL reset_idle got %b want %b", outs(), exp); end
  endtask

  task automatic test_exact_purchase();
    applyStimulus(2'b01, 0, 0, 0, 0); exp = 9'b100000_001; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL exact_coin5 got %b want %b", outs(), exp); end
    applyStimulus(2'b10, 0, 0, 0, 0); exp = 9'b100000_011; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL exact_coin10 got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 1, 0, 0, 0); exp = 9'b001001_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL exact_sel got %b want %b", outs(), exp); end
    idle_cycles(3); checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL exact_hold got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 0, 0, 1, 0); exp = 9'b000000_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL exact_ack got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 1, 0, 0, 0); exp = 9'b000010_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL idle_sel_short got %b want %b", outs(), exp); end
  endtask

  task automatic test_change();
    applyStimulus(2'b10, 0, 0, 0, 0); applyStimulus(2'b10, 0, 0, 0, 0); exp = 9'b100000_100; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL chg_credit4 got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 1, 0, 0, 0); exp = 9'b001001_001; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL chg_sel got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 0, 0, 1, 0); exp = 9'b000101_001; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL chg_after_disp got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 0, 0, 0, 1); exp = 9'b000000_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL chg_ack_done got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 0, 0, 0, 1); checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL stray_chg_ack got %b want %b", outs(), exp); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(2'b10, 0, 0, 0, 0); exp = {6'b100000, 3'(2 * i)}; checks++;
      if (outs() !== exp) begin failures++; $display("[TB] FAIL ovf_fill%0d got %b want %b", i, outs(), exp); end
    end
    applyStimulus(2'b10, 0, 0, 0, 0); exp = 9'b010000_110; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL ovf_reject got %b want %b", outs(), exp); end
    applyStimulus(2'b11, 0, 0, 0, 0); checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL bad_coin got %b want %b", outs(), exp); end
    applyStimulus(2'b01, 0, 0, 0, 0); exp = 9'b100000_111; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL max_credit got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 0, 1, 0, 0); exp = 9'b000101_111; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL ovf_cancel got %b want %b", outs(), exp); end
    for (int i = 6; i >= 1; i--) begin
      applyStimulus(2'b00, 0, 0, 0, 1); exp = {6'b000101, 3'(i)}; checks++;
      if (outs() !== exp) begin failures++; $display("[TB] FAIL refund_%0d got %b want %b", i, outs(), exp); end
    end
    applyStimulus(2'b00, 0, 0, 0, 1); exp = 9'b000000_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL refund_done got %b want %b", outs(), exp); end
  endtask

  task automatic test_short_and_cancel();
    applyStimulus(2'b10, 0, 0, 0, 0);
    applyStimulus(2'b00, 1, 0, 0, 0); exp = 9'b000010_010; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL short_err got %b want %b", outs(), exp); end
    applyStimulus(2'b10, 0, 0, 0, 0); exp = 9'b100000_100; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL still_collect got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 1, 1, 0, 0); exp = 9'b000101_100; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL sel_cancel got %b want %b", outs(), exp); end
    idle_cycles(2); checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL chg_wait got %b want %b", outs(), exp); end
    for (int i = 3; i >= 0; i--) applyStimulus(2'b00, 0, 0, 0, 1);
    exp = 9'b000000_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL sc_refund got %b want %b", outs(), exp); end
    applyStimulus(2'b01, 0, 0, 0, 0); applyStimulus(2'b10, 0, 0, 0, 0); applyStimulus(2'b00, 1, 0, 0, 0);
    applyStimulus(2'b01, 0, 0, 0, 0); exp = 9'b011001_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL disp_coin_rej got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 1, 1, 0, 0); exp = 9'b001001_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL disp_ignore got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 0, 0, 1, 0); exp = 9'b000000_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL disp_done got %b want %b", outs(), exp); end
  endtask

  task automatic test_timeout();
    applyStimulus(2'b01, 0, 0, 0, 0);
    idle_cycles(199); exp = 9'b000000_001; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL to_early got %b want %b", outs(), exp); end
    idle_cycles(1); exp = 9'b000101_001; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL to_fire got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 0, 0, 0, 1); exp = 9'b000000_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL to_refund got %b want %b", outs(), exp); end
    applyStimulus(2'b01, 0, 0, 0, 0);
    idle_cycles(198);
    applyStimulus(2'b00, 1, 0, 0, 0); exp = 9'b000010_001; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL to_reload got %b want %b", outs(), exp); end
    idle_cycles(199); exp = 9'b000000_001; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL to_reload_early got %b want %b", outs(), exp); end
    idle_cycles(1); exp = 9'b000101_001; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL to_reload_fire got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 0, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    applyStimulus(2'b01, 0, 0, 0, 0); applyStimulus(2'b10, 0, 0, 0, 0); applyStimulus(2'b00, 1, 0, 0, 0);
    exp = 9'b001001_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL ar_dispense got %b want %b", outs(), exp); end
    rst = 1'b0;
    #2;
    exp = 9'b000000_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL ar_immediate got %b want %b", outs(), exp); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(1); checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL ar_after got %b want %b", outs(), exp); end
    applyStimulus(2'b10, 0, 0, 0, 0); exp = 9'b100000_010; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL ar_coin got %b want %b", outs(), exp); end
    applyStimulus(2'b00, 0, 1, 0, 0); applyStimulus(2'b00, 0, 0, 0, 1); applyStimulus(2'b00, 0, 0, 0, 1);
    exp = 9'b000000_000; checks++;
    if (outs() !== exp) begin failures++; $display("[TB] FAIL ar_cleanup got %b want %b", outs(), exp); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; coin = 2'b00; sel = 1'b0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_exact_purchase();
    test_change();
    test_overflow();
    test_short_and_cancel();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
